// File: rtl/s2_cell_array.sv
`default_nettype none
// ============================================================================
// Module   : s2_cell_array
// Purpose  : Row of W independent S2-style logic cells. Each cell is a
//            registered 4:1 selector. Its four data constants and its two
//            select-combining modes come from a serially loaded
//            configuration word of 6*W bits.
//            A shadow register collects the incoming configuration while the
//            datapath keeps running on the active register. The shadow is
//            copied to the active register in one step, on the edge that
//            samples the last configuration bit.
// Ports    : clk        rising-edge clock
//            clr_n      asynchronous active-low reset
//            cfg_start  begin/restart a configuration load
//            cfg_valid  qualifies cfg_bit
//            cfg_bit    serial configuration bit, MSB of the word first
//            cfg_ready  high while a load is in progress
//            cfg_done   one-cycle pulse when a new configuration is active
//            in_valid   qualifies a0/a1/b0/b1
//            a0,a1,b0,b1 per-cell select inputs (bit i feeds cell i)
//            out        registered cell outputs
//            out_valid  out was updated this cycle
// Options  : S2_ARRAY_PIPE2_EN - adds a second output register stage
//            (out/out_valid latency 2 instead of 1).
// Cell i configuration: CFG[6i+5:6i] = {mb, ma, D11, D10, D01, D00}
// Revision : 1.0 - initial release
// ============================================================================
module s2_cell_array #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         cfg_start,
    input  logic         cfg_valid,
    input  logic         cfg_bit,
    output logic         cfg_ready,
    output logic         cfg_done,
    input  logic         in_valid,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] b1,
    output logic [W-1:0] out,
    output logic         out_valid
);

    localparam int CFG_BITS = 6 * W;
    localparam int CNT_W    = $clog2(CFG_BITS);
    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(CFG_BITS - 1);

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CFG_BITS-1:0]  shadow_q, shadow_d;
    logic [CFG_BITS-1:0]  active_q, active_d;
    // live_q marks that a complete configuration has been installed since
    // reset. It keeps the datapath running through a reload and keeps it
    // disabled during the very first load.
    logic                 live_q, live_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;

    logic [W-1:0]         w_cell_res;
    logic [W-1:0]         out1_q, out1_d;
    logic                 vld1_q, vld1_d;

    // ------------------------------------------------------------------
    // Configuration FSM: next-state / outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        live_d   = live_q;
        done_d   = 1'b0;

        if (cfg_start) begin
            // Restart wins over a same-cycle cfg_valid; that bit is dropped.
            state_d  = LOAD;
            cnt_d    = '0;
            shadow_d = '0;
        end else if ((state_q == LOAD) && cfg_valid) begin
            shadow_d = {shadow_q[CFG_BITS-2:0], cfg_bit};
            if (cnt_q == C_LAST_IDX) begin
                active_d = shadow_d;
                state_d  = RUN;
                cnt_d    = '0;
                live_d   = 1'b1;
                done_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= UNCFG;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            live_q   <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            live_q   <= live_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign cfg_ready = ready_q;
    assign cfg_done  = done_q;

    // ------------------------------------------------------------------
    // Cell evaluation on the active configuration. The swap edge still
    // sees the old active_q, so the sample taken with the last config bit
    // uses the old configuration.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < W; i++) begin : g_cell
        logic [5:0] w_f;
        logic       w_sa;
        logic       w_sb;
        assign w_f  = active_q[6*i +: 6];
        assign w_sa = w_f[4] ? (a0[i] | a1[i]) : (a0[i] & a1[i]);
        assign w_sb = w_f[5] ? (b0[i] & b1[i]) : (b0[i] | b1[i]);
        assign w_cell_res[i] = w_f[{w_sb, w_sa}];
    end

    // ------------------------------------------------------------------
    // Output stage 1
    // ------------------------------------------------------------------
    always_comb begin
        out1_d = out1_q;
        vld1_d = 1'b0;
        if (in_valid && live_q) begin
            out1_d = w_cell_res;
            vld1_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            out1_q <= '0;
            vld1_q <= 1'b0;
        end else begin
            out1_q <= out1_d;
            vld1_q <= vld1_d;
        end
    end

`ifdef S2_ARRAY_PIPE2_EN
    // Second stage simply delays stage 1, so results keep the configuration
    // that was active when the inputs were sampled.
    logic [W-1:0] out2_q;
    logic         vld2_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            out2_q <= '0;
            vld2_q <= 1'b0;
        end else begin
            out2_q <= out1_q;
            vld2_q <= vld1_q;
        end
    end

    assign out       = out2_q;
    assign out_valid = vld2_q;
`else
    assign out       = out1_q;
    assign out_valid = vld1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_s2_cell_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_s2_cell_array
// Purpose  : Self-checking bench for s2_cell_array (W=8). A cycle-level
//            reference model predicts out/out_valid/cfg_ready/cfg_done each
//            cycle. Directed literal expectations pin key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_s2_cell_array;

    localparam int W  = 8;
    localparam int CB = 6 * W;
`ifdef S2_ARRAY_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // Cell fields {mb, ma, D11, D10, D01, D00}
    localparam logic [47:0] C_CFG_A = {8{6'b000110}};
    localparam logic [47:0] C_CFG_B = {{7{6'b000110}}, 6'b010110};
    localparam logic [47:0] C_CFG_C = {8{6'b001001}};

    logic         clk;
    logic         clr_n;
    logic         cfg_start;
    logic         cfg_valid;
    logic         cfg_bit;
    logic         cfg_ready;
    logic         cfg_done;
    logic         in_valid;
    logic [W-1:0] a0, a1, b0, b1;
    logic [W-1:0] out;
    logic         out_valid;

    s2_cell_array #(.W(W)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .in_valid  (in_valid),
        .a0        (a0),
        .a1        (a1),
        .b0        (b0),
        .b1        (b1),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit          m_loading;
    bit          m_bits[$];
    logic [47:0] m_active;
    bit          m_live;
    bit          m_ready;
    bit          m_done;
    logic [7:0]  m_o1, m_o2;
    bit          m_v1, m_v2;

    function automatic logic [7:0] eval(input logic [47:0] cfg,
                                        input logic [7:0] x0, input logic [7:0] x1,
                                        input logic [7:0] y0, input logic [7:0] y1);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            int f;
            int sa;
            int sb;
            f  = int'(cfg[6*i +: 6]);
            sa = ((f >> 4) & 1) != 0 ? int'(x0[i] | x1[i]) : int'(x0[i] & x1[i]);
            sb = ((f >> 5) & 1) != 0 ? int'(y0[i] & y1[i]) : int'(y0[i] | y1[i]);
            r[i] = ((f >> (2 * sb + sa)) & 1) != 0;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_loading = 0;
        m_bits.delete();
        m_active  = '0;
        m_live    = 0;
        m_ready   = 0;
        m_done    = 0;
        m_o1 = '0; m_o2 = '0;
        m_v1 = 0;  m_v2 = 0;
    endtask

    task automatic model_step();
        logic [7:0] nxt_o;
        bit         nxt_v;
        nxt_o = m_o1;
        nxt_v = 0;
        if (in_valid && m_live) begin
            nxt_o = eval(m_active, a0, a1, b0, b1);
            nxt_v = 1;
        end
        m_o2 = m_o1; m_v2 = m_v1;
        m_o1 = nxt_o; m_v1 = nxt_v;

        m_done = 0;
        if (cfg_start) begin
            m_loading = 1;
            m_bits.delete();
        end else if (m_loading && cfg_valid) begin
            m_bits.push_back(cfg_bit);
            if (m_bits.size() == CB) begin
                for (int k = 0; k < CB; k++) m_active[CB-1-k] = m_bits[k];
                m_bits.delete();
                m_loading = 0;
                m_live    = 1;
                m_done    = 1;
            end
        end
        m_ready = m_loading;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        if (!clr_n) model_reset();
        else        model_step();
        #1;
        if (clr_n) begin
            check("cyc_out",       out,       (LAT == 2) ? m_o2 : m_o1);
            check("cyc_out_valid", out_valid, (LAT == 2) ? m_v2 : m_v1);
            check("cyc_cfg_ready", cfg_ready, m_ready);
            check("cyc_cfg_done",  cfg_done,  m_done);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all driving happens on the falling edge)
    // ------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic rnd_inputs();
        in_valid = 1'($urandom_range(0, 1));
        a0 = 8'($urandom); a1 = 8'($urandom);
        b0 = 8'($urandom); b1 = 8'($urandom);
    endtask

    task automatic send_bits(input logic [47:0] cfg, input int from, input int n, input bit rnd);
        for (int i = from; i < from + n; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = cfg[CB-1-i];
            if (rnd) rnd_inputs();
            step();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic set_in(input logic [7:0] x0, input logic [7:0] x1,
                          input logic [7:0] y0, input logic [7:0] y1);
        in_valid = 1'b1;
        a0 = x0; a1 = x1; b0 = y0; b1 = y1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
        in_valid = 1'b0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;

        // Reset / UNCFG
        repeat (3) step();
        check("rst_out",       out,       8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_cfg_ready", cfg_ready, 1'b0);
        check("rst_cfg_done",  cfg_done,  1'b0);
        clr_n = 1'b1;
        set_in(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        repeat (4) step();
        check("uncfg_out",       out,       8'h00);
        check("uncfg_out_valid", out_valid, 1'b0);
        check("uncfg_cfg_ready", cfg_ready, 1'b0);

        // Full load from UNCFG (datapath stays disabled during it)
        start_load();
        check("load_ready_rise", cfg_ready, 1'b1);
        send_bits(C_CFG_A, 0, CB, 1'b1);
        check("load_done_pulse", cfg_done,  1'b1);
        check("load_ready_fall", cfg_ready, 1'b0);
        check("model_cfg_a",     m_active,  C_CFG_A);
        set_in(8'hFF, 8'h00, 8'hFF, 8'h00);
        step();
        check("load_done_width", cfg_done, 1'b0);
        repeat (LAT - 1) step();
        check("load_out",       out,       8'hFF);
        check("load_out_valid", out_valid, 1'b1);

        // Mode bit: cell 0 ma=1
        in_valid = 1'b0;
        start_load();
        send_bits(C_CFG_B, 0, CB, 1'b0);
        set_in(8'h01, 8'h00, 8'hFF, 8'h00);
        repeat (LAT) step();
        check("mode_out", out, 8'hFE);

        // Hot reload with constant stream: old result FE, new result 00
        set_in(8'hFF, 8'h00, 8'hFF, 8'h00);
        start_load();
        send_bits(C_CFG_C, 0, CB, 1'b0);
        check("hot_done", cfg_done, 1'b1);
        repeat (LAT - 1) step();
        check("hot_old_cfg", out, 8'hFE);
        step();
        check("hot_new_cfg", out, 8'h00);
        check("hot_no_bubble", out_valid, 1'b1);

        // Hot reload with random stream, model checks every cycle
        start_load();
        send_bits(C_CFG_B, 0, CB, 1'b1);
        repeat (4) begin rnd_inputs(); step(); end

        // Abort: 20 bits, restart with a same-cycle cfg_valid, then 48 bits
        start_load();
        send_bits(C_CFG_C, 0, 20, 1'b1);
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
        step();
        cfg_start = 1'b0;
        send_bits(C_CFG_A, 0, 28, 1'b1);
        check("abort_no_done",  cfg_done,  1'b0);
        check("abort_ready",    cfg_ready, 1'b1);
        send_bits(C_CFG_A, 28, 20, 1'b1);
        check("abort_done",     cfg_done,  1'b1);
        check("model_cfg_abort", m_active, C_CFG_A);

        // Reset mid-load after 30 bits
        start_load();
        send_bits(C_CFG_C, 0, 30, 1'b1);
        clr_n = 1'b0;
        #1;
        check("midrst_out",       out,       8'h00);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_cfg_ready", cfg_ready, 1'b0);
        repeat (2) step();
        clr_n = 1'b1;
        set_in(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) step();
        check("midrst_ignored", out_valid, 1'b0);
        start_load();
        send_bits(C_CFG_C, 0, CB, 1'b0);
        check("reload_done", cfg_done, 1'b1);
        repeat (LAT) step();
        check("reload_out", out, 8'hFF);

        in_valid = 1'b0;
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
